// File: rtl/statled_sched.sv
// statled_sched: frame-aligned round-robin status LED scheduler (clk, rst async; req[3:0], code0..code3 in; status, grant, busy, frame_end out)
module statled_sched #(
  parameter int FRAME_CLKCNT = 17000,
  parameter int REPEAT = 2,
  parameter int tDLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [2:0] code0,
  input  logic [2:0] code1,
  input  logic [2:0] code2,
  input  logic [2:0] code3,
  output logic [3:0] status,
  output logic [3:0] grant,
  output logic       busy,
  output logic       frame_end
);
  localparam int CW = $clog2(FRAME_CLKCNT);
  if (FRAME_CLKCNT < 2 || FRAME_CLKCNT > (1 << 24) || REPEAT < 1 || REPEAT > 15 || tDLY < 0) begin : g_bad
    $error("statled_sched: illegal parameter");
  end
  typedef enum logic {IDLE, SHOW} state_t;
  state_t        st;
  logic [CW-1:0] cnt;
  logic [3:0]    rep;
  logic [1:0]    ptr;
  logic [1:0]    win;
  logic [3:0]    elig;
  logic [2:0]    code [4];
  logic          any;
  logic          hold;
  assign code = '{code0, code1, code2, code3};
  for (genvar g = 0; g < 4; g++) begin : g_elig
    assign elig[g] = req[g] && code[g] != 3'd0 && code[g] != 3'd7;
  end
  assign frame_end = cnt == CW'(FRAME_CLKCNT - 1);
  assign hold = st == SHOW && |(grant & elig) && rep < 4'(REPEAT - 1);
  always_comb begin
    win = ptr;
    any = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (elig[ptr + 2'(i)]) begin
        win = ptr + 2'(i);
        any = 1'b1;
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt    <= '0;
      st     <= IDLE;
      rep    <= '0;
      ptr    <= '0;
      status <= '0;
      grant  <= '0;
      busy   <= 1'b0;
    end else begin
      cnt <= frame_end ? '0 : cnt + CW'(1);
      if (frame_end) begin
        if (hold)
          rep <= rep + 4'd1;
        else if (any) begin
          st     <= SHOW;
          busy   <= 1'b1;
          grant  <= 4'b0001 << win;
          status <= {1'b0, code[win]};
          rep    <= '0;
          ptr    <= win + 2'd1;
        end else begin
          st     <= IDLE;
          busy   <= 1'b0;
          grant  <= '0;
          status <= '0;
          rep    <= '0;
        end
      end
    end
endmodule

// File: tb/tb_statled_sched.sv
// tb_statled_sched: randomized and directed checks of statled_sched against a frame-level reference model
module tb_statled_sched;
  localparam int F = 8;
  localparam int R = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [2:0] code [4] = '{default: 3'd1};
  logic [3:0] status;
  logic [3:0] grant;
  logic       busy;
  logic       frame_end;
  int errors = 0;
  int checks = 0;
  int m_cnt, m_own, m_frames, m_next, m_code;
  statled_sched #(.FRAME_CLKCNT(F), .REPEAT(R), .tDLY(1)) dut (
    .clk(clk), .rst(rst), .req(req),
    .code0(code[0]), .code1(code[1]), .code2(code[2]), .code3(code[3]),
    .status(status), .grant(grant), .busy(busy), .frame_end(frame_end)
  );
  always #5 clk = ~clk;
  function automatic bit elig(int n);
    return req[n] && code[n] >= 3'd1 && code[n] <= 3'd6;
  endfunction
  function automatic void model_reset();
    m_cnt = 0;
    m_own = -1;
    m_frames = 0;
    m_next = 0;
    m_code = 0;
  endfunction
  function automatic void model_frame();
    int w = -1;
    if (m_own >= 0 && elig(m_own) && m_frames < R) begin
      m_frames++;
      return;
    end
    for (int k = 0; k < 4; k++)
      if (w < 0 && elig((m_next + k) % 4)) w = (m_next + k) % 4;
    if (w < 0) begin
      m_own = -1;
      m_code = 0;
      m_frames = 0;
    end else begin
      m_own = w;
      m_code = int'(code[w]);
      m_frames = 1;
      m_next = (w + 1) % 4;
    end
  endfunction
  function automatic logic [9:0] exp_vec();
    return {4'(m_code), m_own < 0 ? 4'd0 : 4'(1 << m_own), 1'(m_own >= 0), 1'(m_cnt == F - 1)};
  endfunction
  task automatic tick();
    if (m_cnt == F - 1) begin
      model_frame();
      m_cnt = 0;
    end else m_cnt++;
    @(posedge clk);
    #1;
  endtask
  task automatic restart();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({status, grant, busy, frame_end} !== 10'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 000", {status, grant, busy, frame_end});
    end
    rst = 1'b0;
    model_reset();
    repeat (F - 2) tick();
    checks++;
    if (frame_end !== 1'b0) begin
      errors++;
      $display("FAIL early_frame_end: got %b expected 0", frame_end);
    end
    tick();
    checks++;
    if (frame_end !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_end: got %b expected 1", frame_end);
    end
  endtask
  task automatic test_single();
    restart();
    req = 4'b0001;
    code[0] = 3'd3;
    repeat (F) begin
      tick();
      checks++;
      if ({status, grant, busy, frame_end} !== exp_vec()) begin
        errors++;
        $display("FAIL single_model: got %h expected %h", {status, grant, busy, frame_end}, exp_vec());
      end
    end
    checks++;
    if (grant !== 4'b0001 || status !== 4'd3) begin
      errors++;
      $display("FAIL single_first_grant: got grant=%b status=%0d expected 0001/3", grant, status);
    end
    repeat (5 * F) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || status !== 4'd3) begin
        errors++;
        $display("FAIL single_hold: got grant=%b status=%0d expected 0001/3", grant, status);
      end
    end
  endtask
  task automatic test_round_robin();
    restart();
    req = 4'b1111;
    code = '{3'd1, 3'd2, 3'd3, 3'd4};
    repeat (F) tick();
    for (int k = 0; k < 5; k++)
      repeat (2 * F) begin
        checks++;
        if (status !== 4'((k % 4) + 1) || {status, grant, busy, frame_end} !== exp_vec()) begin
          errors++;
          $display("FAIL round_robin: got status=%0d grant=%b expected status=%0d model=%h", status, grant, (k % 4) + 1, exp_vec());
        end
        tick();
      end
  endtask
  task automatic test_early_release();
    restart();
    req = 4'b0001;
    code[0] = 3'd2;
    repeat (F + 3) tick();
    req = 4'b0000;
    repeat (F - 3) begin
      tick();
      checks++;
      if ({status, grant, busy, frame_end} !== exp_vec()) begin
        errors++;
        $display("FAIL early_model: got %h expected %h", {status, grant, busy, frame_end}, exp_vec());
      end
    end
    checks++;
    if (grant !== 4'b0000 || status !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_release: got grant=%b status=%0d busy=%b expected 0000/0/0", grant, status, busy);
    end
  endtask
  task automatic test_invalid_code();
    restart();
    req = 4'b0011;
    code[0] = 3'd7;
    code[1] = 3'd5;
    repeat (F) tick();
    checks++;
    if (grant !== 4'b0010 || status !== 4'd5) begin
      errors++;
      $display("FAIL invalid_grant: got grant=%b status=%0d expected 0010/5", grant, status);
    end
    repeat (6 * F) begin
      tick();
      checks++;
      if (status === 4'd7 || grant[0] !== 1'b0 || {status, grant, busy, frame_end} !== exp_vec()) begin
        errors++;
        $display("FAIL invalid_hold: got %h expected %h", {status, grant, busy, frame_end}, exp_vec());
      end
    end
  endtask
  task automatic test_code_change();
    restart();
    req = 4'b0001;
    code[0] = 3'd2;
    repeat (F) tick();
    code[0] = 3'd6;
    repeat (2 * F - 1) begin
      tick();
      checks++;
      if (status !== 4'd2) begin
        errors++;
        $display("FAIL code_latched: got status=%0d expected 2", status);
      end
    end
    tick();
    checks++;
    if (status !== 4'd6 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL code_regrant: got status=%0d grant=%b expected 6/0001", status, grant);
    end
  endtask
  task automatic test_async_reset();
    restart();
    req = 4'b1111;
    code = '{3'd1, 3'd2, 3'd3, 3'd4};
    repeat (3 * F + 4) tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL async_pre: got grant=%b expected 0010", grant);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({status, grant, busy, frame_end} !== 10'd0) begin
      errors++;
      $display("FAIL async_immediate: got %h expected 000", {status, grant, busy, frame_end});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (F - 1) tick();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL async_wait: got grant=%b expected 0000", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || status !== 4'd1) begin
      errors++;
      $display("FAIL async_regrant: got grant=%b status=%0d expected 0001/1", grant, status);
    end
  endtask
  task automatic test_random();
    restart();
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      if ($urandom_range(0, 15) == 0) code[$urandom_range(0, 3)] = 3'($urandom);
      tick();
      checks++;
      if ({status, grant, busy, frame_end} !== exp_vec()) begin
        errors++;
        $display("FAIL random_model: got %h expected %h req=%b", {status, grant, busy, frame_end}, exp_vec(), req);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_invalid_code();
    test_code_change();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
